// File: rtl/ro_fingerprint_reader.sv
// Ring-oscillator fingerprint measurement: gates the counter for a fixed window,
// takes the modular count delta, checks it against a pass band, and serves it bytewise.
module ro_fingerprint_reader #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter logic [31:0] MIN_COUNT     = 32'd256,
    parameter logic [31:0] MAX_COUNT     = 32'd768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rd_next,
    input  logic [31:0] ro_count,
    output logic        ro_enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [31:0] result,
    output logic [7:0]  data_out
);

    typedef enum logic [2:0] {IDLE, GATE, SETTLE, SNAP, CMP} state_t;

    localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

    state_t      state;
    logic [31:0] start_cnt;
    logic [31:0] delta;
    logic [15:0] win_cnt;
    logic        settle_cnt;
    logic [1:0]  ptr;
    logic        in_band;

    assign in_band  = (delta >= MIN_COUNT) && (delta <= MAX_COUNT);
    assign busy     = (state != IDLE);
    assign data_out = result[{ptr, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_cnt  <= '0;
            delta      <= '0;
            win_cnt    <= '0;
            settle_cnt <= 1'b0;
            ptr        <= '0;
            ro_enable  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        start_cnt <= ro_count;
                        ro_enable <= 1'b1;
                        win_cnt   <= '0;
                        state     <= GATE;
                    end
                end
                GATE: begin
                    win_cnt <= win_cnt + 16'd1;
                    if (win_cnt == WIN_LAST) begin
                        ro_enable  <= 1'b0;
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                    end
                end
                // Two idle cycles let the counter's last in-window increment land.
                SETTLE: begin
                    if (settle_cnt) begin
                        state <= SNAP;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                SNAP: begin
                    delta <= ro_count - start_cnt;
                    state <= CMP;
                end
                CMP: begin
                    result <= delta;
                    pass   <= in_band;
                    fail   <= ~in_band;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fresh commit always points the readout back at the LSB.
            if (state == CMP) begin
                ptr <= '0;
            end else if (rd_next) begin
                ptr <= ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ro_fingerprint_reader.sv
// Bench for ro_fingerprint_reader: timeline-based reference model with per-cycle
// comparison, directed scenarios with literal expectations, then randomized traffic.
module tb_ro_fingerprint_reader;

    localparam int W = 16;
    localparam logic [31:0] MINC = 32'd8;
    localparam logic [31:0] MAXC = 32'd24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rd_next = 1'b0;
    logic [31:0] ro_count = '0;
    logic        ro_enable, busy, done, pass, fail;
    logic [31:0] result;
    logic [7:0]  data_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Oscillator counter stand-in: adds incs[k] on the k-th enabled cycle of a window.
    logic [31:0] incs [W];
    int          k = 0;
    logic        preload_req = 1'b0;
    logic [31:0] preload_val = '0;

    // Reference model: position on the measurement timeline, relative to the start edge.
    int          m_c = -1;
    logic        m_en = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0;
    logic [31:0] m_result = '0, m_start = '0, m_snap = '0;
    logic [1:0]  m_ptr = '0;

    ro_fingerprint_reader #(
        .WINDOW_CYCLES(W),
        .MIN_COUNT(MINC),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rd_next(rd_next),
        .ro_count(ro_count),
        .ro_enable(ro_enable),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail(fail),
        .result(result),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload_req) begin
            ro_count <= preload_val;
        end else if (ro_enable) begin
            ro_count <= ro_count + incs[k];
            k <= (k == W - 1) ? 0 : k + 1;
        end else begin
            k <= 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        int          c;
        logic [31:0] s;
        logic        d;
        if (!rst_n) begin
            m_c <= -1; m_en <= 1'b0; m_done <= 1'b0; m_result <= '0;
            m_pass <= 1'b0; m_fail <= 1'b0; m_ptr <= '0;
        end else begin
            c = m_c;
            d = 1'b0;
            if (c < 0) begin
                if (start) begin
                    c = 0;
                    m_start <= ro_count;
                end
            end else begin
                c = c + 1;
                if (c == W + 3) m_snap <= ro_count;
                if (c == W + 4) begin
                    s = m_snap - m_start;
                    m_result <= s;
                    m_pass <= (s >= MINC) && (s <= MAXC);
                    m_fail <= !((s >= MINC) && (s <= MAXC));
                    d = 1'b1;
                    c = -1;
                end
            end
            m_c    <= c;
            m_done <= d;
            m_en   <= (c >= 0) && (c < W);
            if (d) m_ptr <= '0;
            else if (rd_next) m_ptr <= m_ptr + 2'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ro_enable", 32'(ro_enable), 32'(m_en));
            chk("busy", 32'(busy), 32'(m_c >= 0));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("fail", 32'(fail), 32'(m_fail));
            chk("result", result, m_result);
            chk("data_out", 32'(data_out), 32'(8'(m_result >> (8 * int'(m_ptr)))));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_incs(input logic [31:0] v);
        for (int i = 0; i < W; i++) incs[i] = v;
    endtask

    task automatic preload(input logic [31:0] v);
        preload_val = v;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    // Pulses start for one edge, returns edges from start to done, enabled cycles, done count.
    task automatic measure(output int lat, output int en_cyc, output int dn);
        lat = -1; en_cyc = 0; dn = 0;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            en_cyc += int'(ro_enable);
            if (done) begin
                lat = n - 1;
                dn++;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || m_c >= 0) && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(n < 60), 32'd1);
    endtask

    initial begin
        int lat, en_cyc, dn, t0, t1;
        fill_incs(32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_ro_enable", 32'(ro_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);

        // Nominal: +1 per enabled cycle.
        measure(lat, en_cyc, dn);
        chk("nom_latency", 32'(lat), 32'd20);
        chk("nom_enable_cycles", 32'(en_cyc), 32'd16);
        chk("nom_result", result, 32'd16);
        chk("nom_pass", 32'(pass), 32'd1);
        chk("nom_fail", 32'(fail), 32'd0);
        tick();

        // Counter wraps across the window.
        preload(32'hFFFF_FFF8);
        measure(lat, en_cyc, dn);
        chk("wrap_result", result, 32'h0000_0010);
        chk("wrap_pass", 32'(pass), 32'd1);
        tick();

        fill_incs(32'd0);
        measure(lat, en_cyc, dn);
        chk("frozen_result", result, 32'd0);
        chk("frozen_pass", 32'(pass), 32'd0);
        chk("frozen_fail", 32'(fail), 32'd1);
        tick();

        fill_incs(32'd2);
        measure(lat, en_cyc, dn);
        chk("fast_result", result, 32'd32);
        chk("fast_fail", 32'(fail), 32'd1);
        tick();

        // Readout walk over the bytes of 0x12345678.
        fill_incs(32'd0);
        incs[0] = 32'h1234_5678;
        measure(lat, en_cyc, dn);
        chk("rd_result", result, 32'h1234_5678);
        chk("rd_byte0", 32'(data_out), 32'h78);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("rd_byte1", 32'(data_out), 32'h56);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("rd_byte2", 32'(data_out), 32'h34);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("rd_byte3", 32'(data_out), 32'h12);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("rd_byte_wrap", 32'(data_out), 32'h78);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("rd_byte1_again", 32'(data_out), 32'h56);

        // rd_next held through the commit: the commit's pointer reset wins.
        fill_incs(32'd1);
        incs[3] = 32'h0000_AB00;
        rd_next = 1'b1;
        measure(lat, en_cyc, dn);
        chk("cmp_wins_data", 32'(data_out), 32'h0F);
        rd_next = 1'b0;
        tick();

        // Second start during GATE is ignored.
        fill_incs(32'd1);
        start = 1'b1;
        en_cyc = 0; dn = 0;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (n == 6) start = 1'b1;
            if (n == 7) start = 1'b0;
            en_cyc += int'(ro_enable);
            dn += int'(done);
        end
        chk("rej_enable_cycles", 32'(en_cyc), 32'd16);
        chk("rej_done_count", 32'(dn), 32'd1);

        // Held start: back-to-back measurements.
        start = 1'b1;
        t0 = -1; t1 = -1;
        for (int n = 1; n <= 80 && t1 < 0; n++) begin
            tick();
            if (done) begin
                if (t0 < 0) t0 = cyc;
                else t1 = cyc;
            end
        end
        start = 1'b0;
        chk("held_spacing", 32'(t1 - t0), 32'(W + 5));
        wait_idle("held");

        // Reset mid-GATE after a passing result.
        measure(lat, en_cyc, dn);
        chk("pre_reset_pass", 32'(pass), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ro_enable", 32'(ro_enable), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_fail", 32'(fail), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_data_out", 32'(data_out), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int i = 0; i < W; i++) begin
                case (mode)
                    0: incs[i] = 32'($urandom_range(0, 2));
                    1: incs[i] = $urandom;
                    2: incs[i] = 32'($urandom_range(0, 1));
                    default: incs[i] = 32'($urandom_range(0, 3));
                endcase
            end
            if ($urandom_range(0, 2) == 0) preload($urandom);
            for (int n = 0; n < 40; n++) begin
                start = ($urandom_range(0, 3) == 0);
                rd_next = $urandom_range(0, 1) == 1;
                tick();
            end
            start = 1'b0;
            rd_next = 1'b0;
            wait_idle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_fingerprint_reader.md
# ro_fingerprint_reader

Measurement controller for the silicon-fingerprint ring oscillator. It drives the oscillator counter's enable for a fixed window of `clk` cycles, then snapshots the 32-bit count before and after the window and computes the modular delta. It compares the delta against a pass band and exposes the 32-bit result one byte at a time on the 8-bit user interface. It sits between the top-level I/O decode and the ring oscillator counter, and is the only driver of that counter's enable.

## Interface
- `WINDOW_CYCLES`, default 1024: gate length in `clk` cycles; legal range 1..65535.
- `MIN_COUNT`, default 32'd256: lower pass bound, inclusive.
- `MAX_COUNT`, default 32'd768: upper pass bound, inclusive. Requires `MIN_COUNT <= MAX_COUNT`.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset `rst_n`, asynchronous, active-low; clock `clk`.
- `start`, in, 1: request one measurement; sampled only in IDLE.
- `rd_next`, in, 1: advance the readout byte pointer; one step per cycle high.
- `ro_count`, in, 32: free-running oscillator edge count from the counter.
- `ro_enable`, out, 1: registered enable to the oscillator counter.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a result is committed.
- `pass`, out, 1: last committed delta is within [`MIN_COUNT`, `MAX_COUNT`]; held until the next commit.
- `fail`, out, 1: equals ~`pass` after the first commit; 0 before it.
- `result`, out, 32: last committed delta; held until the next commit.
- `data_out`, out, 8: byte of `result` selected by the pointer.

## Operation
- FSM states: IDLE, GATE, SETTLE, SNAP, CMP. All outputs are registered except `busy` and `data_out`, which decode state and pointer.
- IDLE, on the edge where `start`=1:
  - `start_cnt` <= `ro_count`.
  - `ro_enable` <= 1.
  - `win_cnt` <= 0.
  - Go to GATE.
- GATE:
  - `win_cnt` increments each cycle.
  - On the edge where `win_cnt == WINDOW_CYCLES-1`: `ro_enable` <= 0, `settle_cnt` <= 0, go to SETTLE.
  - `ro_enable` is therefore high for exactly `WINDOW_CYCLES` cycles.
- SETTLE: wait 2 cycles so the counter's final in-window increment lands, then go to SNAP.
- SNAP: `delta` <= `ro_count - start_cnt`, computed modulo 2^32 (wrap of the counter is transparent). Go to CMP.
- CMP, in one edge:
  - `result` <= `delta`.
  - `pass` <= (`delta >= MIN_COUNT`) && (`delta <= MAX_COUNT`), both unsigned.
  - `fail` <= ~that.
  - `done` <= 1 for one cycle.
  - Byte pointer <= 0.
  - Go to IDLE.
- Readout:
  - `data_out` = `result[8*ptr +: 8]`; `ptr` is 2 bits, 0 = LSB.
  - `rd_next` increments `ptr` mod 4 (3 -> 0).
  - `rd_next` is accepted in any state.
  - When CMP coincides with `rd_next`, the CMP reset to 0 wins.
- `start` outside IDLE is ignored; there is no queuing.
- `start` held high re-triggers: it is sampled again on the IDLE cycle right after CMP.

## Timing
- Reset values:
  - `ro_enable`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0.
  - `result`=0, `data_out`=0x00, `ptr`=0.
  - State IDLE, `start_cnt`=0, `win_cnt`=0.
- Let edge E0 be the edge where `start` is sampled.
  - `ro_enable` is high after edges E0..E(W-1) and falls at edge EW.
  - SETTLE spans edges EW+1 and EW+2.
  - SNAP is at EW+3.
  - `done`, `pass`, `fail` and `result` update at EW+4.
  - Start-to-`done` latency is `WINDOW_CYCLES`+4 edges.
  - The next `start` is sampled no earlier than EW+5.
- `busy` rises the cycle after E0 and falls in the same cycle that `done` is high.
- Reset asserted mid-operation:
  - Immediately forces IDLE and `ro_enable`=0, and clears `result`, `pass` and `fail`.
  - No `done` is produced.
  - The oscillator counter is not reset by this block.
- `win_cnt` is 16 bits.
- `ro_count` is sampled synchronously only at E0 and in SNAP.

## Test plan
- Reset: assert `rst_n`=0 mid-GATE with `WINDOW_CYCLES`=16 -> `ro_enable`, `busy`, `pass`, `fail` and `done` go to 0 at once; `data_out`=0x00 after release.
- Nominal: `WINDOW_CYCLES`=16, MIN=8, MAX=24; model counter +1 per clk while enabled; pulse `start` -> `done` 20 edges later, `result`=16, `pass`=1, `fail`=0, `ro_enable` high exactly 16 cycles.
- Wrap: model counter preloaded to 0xFFFFFFF8, same setup -> `result`=0x00000010, `pass`=1.
- Out of band:
  - Counter frozen -> `result`=0, `pass`=0, `fail`=1.
  - Counter +2 per clk -> `result`=32, `fail`=1.
- Readout: force delta 0x12345678 -> `data_out` shows 0x78; after successive `rd_next` pulses it shows 0x56, 0x34, 0x12, then 0x78. A new `done` resets it to the LSB.
- Busy rejection: pulse `start` again at cycle 5 of GATE -> window length unchanged, exactly one `done`; `start` held high -> back-to-back measurements `WINDOW_CYCLES`+5 edges apart.
